// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - decode-stage scoreboard: RAW/WAW/write-back slot stalls and GPR/FPR write-back sequencing.
// Optional stall statistics ports are enabled by defining SCOREBOARD_STATS_EN.
module reg_scoreboard #(
  parameter int SHORT_LAT = 1,
  parameter int LONG_LAT  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_rs_use,
  input  logic       id_rt_use,
  input  logic       id_src_fp,
  input  logic [4:0] id_dst,
  input  logic       id_dst_wr,
  input  logic       id_dst_fp,
  input  logic       id_long,
  output logic       stall,
  output logic       issue,
  output logic       wb_en,
  output logic       wb_fp,
  output logic [4:0] wb_dst,
`ifdef SCOREBOARD_STATS_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] stall_raw,
`endif
  output logic       idle
);

  logic [LONG_LAT-1:0] p_valid_q, p_valid_d;
  logic [LONG_LAT-1:0] p_fp_q, p_fp_d;
  logic [4:0]          p_dst_q [LONG_LAT];
  logic [4:0]          p_dst_d [LONG_LAT];
  logic [63:0]         busy_q, busy_d;

  logic dst_real, raw, waw, slot;

  // A GPR r0 destination is architecturally discarded, so it never tracks or conflicts.
  always_comb begin
    dst_real = id_dst_wr & ~(~id_dst_fp & (id_dst == 5'd0));
    raw      = id_valid & ((id_rs_use & busy_q[{id_src_fp, id_rs}]) |
                           (id_rt_use & busy_q[{id_src_fp, id_rt}]));
    waw      = id_valid & dst_real & busy_q[{id_dst_fp, id_dst}];
    slot     = id_valid & dst_real & ~id_long & p_valid_q[SHORT_LAT];
    stall    = raw | waw | slot;
    issue    = id_valid & ~stall & reset;
  end

  always_comb begin
    p_valid_d = '0;
    p_fp_d    = '0;
    for (int i = 0; i < LONG_LAT; i++) p_dst_d[i] = 5'd0;
    for (int i = 0; i < LONG_LAT - 1; i++) begin
      p_valid_d[i] = p_valid_q[i+1];
      p_fp_d[i]    = p_fp_q[i+1];
      p_dst_d[i]   = p_dst_q[i+1];
    end
    busy_d = busy_q;
    if (p_valid_q[0]) busy_d[{p_fp_q[0], p_dst_q[0]}] = 1'b0;
    // Set after the retire clear; WAW stall guarantees the two never target the same bit.
    if (issue && dst_real) begin
      if (id_long) begin
        p_valid_d[LONG_LAT-1] = 1'b1;
        p_fp_d[LONG_LAT-1]    = id_dst_fp;
        p_dst_d[LONG_LAT-1]   = id_dst;
      end else begin
        p_valid_d[SHORT_LAT-1] = 1'b1;
        p_fp_d[SHORT_LAT-1]    = id_dst_fp;
        p_dst_d[SHORT_LAT-1]   = id_dst;
      end
      busy_d[{id_dst_fp, id_dst}] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_valid_q <= '0;
      p_fp_q    <= '0;
      busy_q    <= '0;
      for (int i = 0; i < LONG_LAT; i++) p_dst_q[i] <= 5'd0;
    end else begin
      p_valid_q <= p_valid_d;
      p_fp_q    <= p_fp_d;
      busy_q    <= busy_d;
      for (int i = 0; i < LONG_LAT; i++) p_dst_q[i] <= p_dst_d[i];
    end
  end

  assign wb_en  = p_valid_q[0];
  assign wb_fp  = p_valid_q[0] & p_fp_q[0];
  assign wb_dst = p_valid_q[0] ? p_dst_q[0] : 5'd0;
  assign idle   = ~(|p_valid_q) & ~(|busy_q);

`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] stall_raw_q, stall_raw_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    stall_raw_d    = stall_raw_q;
    if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) stall_cycles_d = stall_cycles_q + 32'd1;
    if (raw && (stall_raw_q != 32'hFFFF_FFFF))      stall_raw_d    = stall_raw_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_q <= '0;
      stall_raw_q    <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      stall_raw_q    <= stall_raw_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign stall_raw    = stall_raw_q;
`endif

endmodule
